lpl_sobel: RTL and testbench

Streaming 3x3 Sobel edge detector for 8-bit grayscale frames, by default 640x480 (307200 pixels). It accepts one raster-order pixel per clock while `iStart` is high. It emits one gradient-magnitude pixel per clock, with `oStart` high, after a fixed latency. It sits between a frame source (SDRAM reader) and a frame sink, and also exposes an intermediate 1-2-1 row sum for debug and verification.

---
 rtl/lpl_sobel_pkg.sv | 21 ++
 rtl/lpl_sobel_linebuf.sv | 46 ++++
 rtl/lpl_sobel.sv | 130 +++++++++++++
 tb/tb_lpl_sobel.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/lpl_sobel_pkg.sv
// Shared constants and helpers for the lpl_sobel streaming edge detector.
package lpl_sobel_pkg;

    localparam int unsigned WIDTH_DEF  = 640;
    localparam int unsigned HEIGHT_DEF = 480;
    localparam int unsigned DW_DEF     = 8;

    // Input-to-output latency at the default line width.
    localparam int unsigned LAT = WIDTH_DEF + 4;

    // Arithmetic widths: 1-2-1 sums, signed gradients, unsigned magnitude.
    localparam int unsigned SUM_W  = 10;
    localparam int unsigned GRAD_W = 11;
    localparam int unsigned MAG_W  = 12;

    // Clamp a 0..2040 magnitude to an 8-bit pixel.
    function automatic logic [7:0] sat8(input logic [MAG_W-1:0] mag);
        return (mag > MAG_W'(255)) ? 8'hFF : mag[7:0];
    endfunction

endpackage

// File: rtl/lpl_sobel_linebuf.sv
// WIDTH-cycle delay line for one video line.
// Ports: clk_i/rst_n clock and async reset; din_i pixel in; dout_o the same
// pixel WIDTH clocks later (registered). RAM contents are not reset.
module lpl_sobel_linebuf #(
    parameter int unsigned WIDTH = 640,
    parameter int unsigned DW    = 8
) (
    input  logic          clk_i,
    input  logic          rst_n,
    input  logic [DW-1:0] din_i,
    output logic [DW-1:0] dout_o
);

    // WIDTH-1 RAM entries plus the output register give a WIDTH-clock delay.
    localparam int unsigned DEPTH = WIDTH - 1;
    localparam int unsigned AW    = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] dout_q;

    always_comb begin
        addr_d = addr_q + AW'(1);
        if (addr_q == AW'(DEPTH - 1)) begin
            addr_d = '0;
        end
    end

    // Read-before-write: the old entry leaves as the new pixel lands.
    always_ff @(posedge clk_i) begin
        mem[addr_q] <= din_i;
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            dout_q <= '0;
        end else begin
            addr_q <= addr_d;
            dout_q <= mem[addr_q];
        end
    end

    assign dout_o = dout_q;

endmodule

// File: rtl/lpl_sobel.sv
// Streaming 3x3 Sobel edge detector, one raster pixel per clock.
// Ports: clk_i/rst_n clock and async reset; iData/iStart input pixel and
// valid; oData/oStart saturated |Gx|+|Gy| and valid, WIDTH+4 clocks later;
// data121 registered bottom-row 1-2-1 sum of the current window.
module lpl_sobel
    import lpl_sobel_pkg::*;
#(
    parameter int unsigned WIDTH  = WIDTH_DEF,
    parameter int unsigned HEIGHT = HEIGHT_DEF,
    parameter int unsigned DW     = DW_DEF
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic [DW-1:0]    iData,
    input  logic             iStart,
    output logic [DW-1:0]    oData,
    output logic             oStart,
    output logic [SUM_W-1:0] data121
);

    localparam int unsigned LATENCY = WIDTH + 4;
    localparam int unsigned CW      = $clog2(WIDTH);
    localparam int unsigned RW      = $clog2(HEIGHT);

    function automatic logic [SUM_W-1:0] sum121(input logic [DW-1:0] a,
                                                input logic [DW-1:0] b,
                                                input logic [DW-1:0] c);
        return SUM_W'(a) + (SUM_W'(b) << 1) + SUM_W'(c);
    endfunction

    // Window: column 3 of the upper rows is taken straight from the line buffers.
    logic [DW-1:0] p11_q, p12_q, p21_q, p22_q, p31_q, p32_q, p33_q;
    logic [DW-1:0] p13, p23;

    lpl_sobel_linebuf #(.WIDTH(WIDTH), .DW(DW)) u_lb_mid (
        .clk_i  (clk_i),
        .rst_n  (rst_n),
        .din_i  (p33_q),
        .dout_o (p23)
    );

    lpl_sobel_linebuf #(.WIDTH(WIDTH), .DW(DW)) u_lb_top (
        .clk_i  (clk_i),
        .rst_n  (rst_n),
        .din_i  (p23),
        .dout_o (p13)
    );

    logic [SUM_W-1:0]         l_q, r_q, t_q, b_q;
    logic signed [GRAD_W-1:0] gx_q, gy_q;
    logic [GRAD_W-1:0]        ax, ay;
    logic [MAG_W-1:0]         mag;
    logic [LATENCY:0]         vld_q;
    logic [CW-1:0]            col_q, col_d;
    logic [RW-1:0]            row_q, row_d;
    logic [DW-1:0]            odata_q, odata_d;
    logic                     in_v, border;

    // Window shift and arithmetic pipeline; free-running so it drains after iStart falls.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            p11_q <= '0; p12_q <= '0;
            p21_q <= '0; p22_q <= '0;
            p31_q <= '0; p32_q <= '0; p33_q <= '0;
            l_q   <= '0; r_q   <= '0; t_q <= '0; b_q <= '0;
            gx_q  <= '0; gy_q  <= '0;
        end else begin
            p33_q <= iData;
            p32_q <= p33_q;
            p31_q <= p32_q;
            p22_q <= p23;
            p21_q <= p22_q;
            p12_q <= p13;
            p11_q <= p12_q;
            l_q   <= sum121(p11_q, p21_q, p31_q);
            r_q   <= sum121(p13,   p23,   p33_q);
            t_q   <= sum121(p11_q, p12_q, p13);
            b_q   <= sum121(p31_q, p32_q, p33_q);
            gx_q  <= $signed({1'b0, r_q}) - $signed({1'b0, l_q});
            gy_q  <= $signed({1'b0, b_q}) - $signed({1'b0, t_q});
        end
    end

    // Output position tracking and border-masked magnitude.
    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        odata_d = '0;
        in_v    = vld_q[LATENCY-1];
        ax      = gx_q[GRAD_W-1] ? $unsigned(-gx_q) : $unsigned(gx_q);
        ay      = gy_q[GRAD_W-1] ? $unsigned(-gy_q) : $unsigned(gy_q);
        mag     = MAG_W'(ax) + MAG_W'(ay);
        if (in_v) begin
            if (!vld_q[LATENCY]) begin
                // First output of a frame: restart at (0,0).
                col_d = '0;
                row_d = '0;
            end else if (col_q == CW'(WIDTH - 1)) begin
                col_d = '0;
                row_d = (row_q == RW'(HEIGHT - 1)) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
        border = (row_d == '0) || (row_d == RW'(HEIGHT - 1)) ||
                 (col_d == '0) || (col_d == CW'(WIDTH - 1));
        if (in_v && !border) begin
            odata_d = DW'(sat8(mag));
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            odata_q <= '0;
        end else begin
            vld_q   <= {vld_q[LATENCY-1:0], iStart};
            col_q   <= col_d;
            row_q   <= row_d;
            odata_q <= odata_d;
        end
    end

    assign oData   = odata_q;
    assign oStart  = vld_q[LATENCY];
    assign data121 = b_q;

endmodule

// File: tb/tb_lpl_sobel.sv
// Scoreboard bench for lpl_sobel on a reduced frame size.
module tb_lpl_sobel;

    localparam int W   = 16;
    localparam int H   = 10;
    localparam int N   = W * H;
    localparam int LAT = W + 4;

    logic       clk_i = 1'b0;
    logic       rst_n = 1'b0;
    logic       iStart = 1'b0;
    logic [7:0] iData = 8'd0;
    logic [7:0] oData;
    logic       oStart;
    logic [9:0] data121;

    lpl_sobel #(.WIDTH(W), .HEIGHT(H), .DW(8)) dut (
        .clk_i   (clk_i),
        .rst_n   (rst_n),
        .iData   (iData),
        .iStart  (iStart),
        .oData   (oData),
        .oStart  (oStart),
        .data121 (data121)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int       due;
        int       od;
        bit       chk_od;
        int       d121;
        bit       chk_121;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   img [N];

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int px(input int r, input int c);
        return img[r * W + c];
    endfunction

    // Reference: direct 3x3 Sobel on the frame image with border forced to 0.
    function automatic int exp_pix(input int k);
        int r, c, gx, gy, mag;
        r = k / W;
        c = k % W;
        if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 0;
        gx = (px(r-1,c+1) + 2*px(r,c+1) + px(r+1,c+1))
           - (px(r-1,c-1) + 2*px(r,c-1) + px(r+1,c-1));
        gy = (px(r+1,c-1) + 2*px(r+1,c) + px(r+1,c+1))
           - (px(r-1,c-1) + 2*px(r-1,c) + px(r-1,c+1));
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        return (mag > 255) ? 255 : mag;
    endfunction

    function automatic bit is_border(input int k);
        return (k / W == 0) || (k / W == H - 1) || (k % W == 0) || (k % W == W - 1);
    endfunction

    // kind: 0 flat, 1 vertical step, 2 horizontal step, 3 single dot, 4 random
    task automatic build(input int kind);
        for (int k = 0; k < N; k++) begin
            case (kind)
                0:       img[k] = 8'h80;
                1:       img[k] = (k % W < W / 2) ? 0 : 255;
                2:       img[k] = (k / W < H / 2) ? 10 : 20;
                3:       img[k] = (k == 3 * W + 5) ? 255 : 0;
                default: img[k] = int'($urandom_range(0, 255));
            endcase
        end
    endtask

    // Drive the first n pixels of img back-to-back and queue the expected outputs.
    task automatic send(input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            @(posedge clk_i);
            #1;
            iStart    = 1'b1;
            iData     = 8'(img[k]);
            e.due     = cyc + 1 + LAT;
            e.od      = exp_pix(k);
            e.chk_od  = is_border(k) || (k + W + 1 < n);
            e.chk_121 = (k + W + 3 < n);
            e.d121    = e.chk_121 ? img[k+W+1] + 2 * img[k+W+2] + img[k+W+3] : 0;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
            iStart = 1'b0;
            iData  = 8'($urandom);
        end
    endtask

    task automatic summary();
        $display("Result: errors=%0d of %0d checks", errors, checks);
    endtask

    // Monitor: pop and compare whenever the DUT presents a valid output.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (!rst_n) begin
                chk("rst_oStart", int'(oStart), 0);
                chk("rst_oData", int'(oData), 0);
                chk("rst_data121", int'(data121), 0);
            end else if (oStart) begin
                if (sb.size() == 0) begin
                    chk("oStart_unexpected", int'(oStart), 0);
                end else begin
                    e = sb.pop_front();
                    chk("latency", cyc, e.due);
                    if (e.chk_od) chk("oData", int'(oData), e.od);
                    if (e.chk_121) chk("data121", int'(data121), e.d121);
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                chk("oStart_missing", int'(oStart), 1);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
        errors++;
        summary();
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk_i);
        #1 rst_n = 1'b1;
        idle(2);

        build(0); send(N); idle(5);
        build(1); send(N); idle(3);
        build(2); send(N); idle(3);
        build(3); send(N); idle(4);
        build(4); send(N); idle(2);

        // Aborted frame, then idle so the next frame restarts the counters.
        build(4); send(N / 2 + 3); idle(4);

        // Reset in the middle of a flat frame, then a fresh flat frame.
        build(0); send(N / 2);
        @(posedge clk_i);
        #1;
        rst_n  = 1'b0;
        iStart = 1'b0;
        sb.delete();
        repeat (3) @(posedge clk_i);
        #1 rst_n = 1'b1;
        idle(2);
        build(0); send(N); idle(3);

        // Two frames back-to-back with no gap.
        build(4); send(N);
        build(1); send(N);
        idle(LAT + 10);

        chk("scoreboard_drained", sb.size(), 0);
        summary();
        $finish;
    end

endmodule
